spi_relay_ctrl: RTL and testbench
=================================

SPI_RELAY_CTRL -- requirements
Module: spi_relay_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, giving the relay register width in bits.
REQ-002 The block SHALL have parameter CMD_WR, default 8'h01, the write command code.
REQ-003 The block SHALL have parameter CMD_RD, default 8'h02, the readback command code.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be synchronous to its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port spi_clk, input, 1 bit: asynchronous SPI clock, mode 0.
REQ-007 The block SHALL have port cs_n, input, 1 bit: asynchronous, active-low chip select.
REQ-008 The block SHALL have port mosi, input, 1 bit: asynchronous serial data in, MSB first.
REQ-009 The block SHALL have port miso, output, 1 bit: serial data out, MSB first.
REQ-010 The block SHALL have port relay_q, output, WIDTH bits: the relay drive register.
REQ-011 The block SHALL have port wr_strobe, output, 1 bit: one-clk pulse when relay_q updates.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a malformed frame.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 spi_clk, cs_n and mosi SHALL each pass through 2-flop synchronizers; edges SHALL be detected from synchronized stage 2 versus a stage-3 delay, giving 3-clk detection latency. clk SHALL be at least 4x the spi_clk frequency.
REQ-015 A frame SHALL be: cs_n fall, an 8-bit command, then WIDTH data bits, then cs_n rise; mosi SHALL be sampled on detected spi_clk rising edges.
REQ-016 The FSM SHALL have states IDLE, CMD, DATA and ABORT.
REQ-017 IDLE->CMD on cs_n fall, with bit_cnt cleared to 0.
REQ-018 CMD->DATA when the 8th bit is sampled; that bit completes the command register.
REQ-019 DATA: sampled bits SHALL shift into the data register.
REQ-020 bit_cnt SHALL saturate at 8+WIDTH+1, marking an overrun.
REQ-021 CMD or DATA -> IDLE on cs_n rise.
REQ-022 ABORT -> IDLE on cs_n rise.
REQ-023 spi_clk edges SHALL be ignored in IDLE and ABORT.
REQ-024 When a cs_n rise and an spi_clk edge are detected in the same clk, the cs_n rise SHALL win and the spi_clk edge SHALL be discarded.
REQ-025 At a cs_n rise, when command==CMD_WR and bit_cnt==8+WIDTH, relay_q SHALL load the data register and wr_strobe SHALL pulse, both in the clk after detection.
REQ-026 At a cs_n rise with command==CMD_WR and any other bit_cnt, frame_err SHALL pulse and relay_q SHALL remain unchanged.
REQ-027 At a cs_n rise with command==CMD_RD, no error SHALL be flagged for any bit_cnt of 8 or more; an early abort is legal.
REQ-028 At a cs_n rise with any other command and bit_cnt of 8 or more, frame_err SHALL pulse.
REQ-029 At a cs_n rise with 1 <= bit_cnt <= 7, frame_err SHALL pulse.
REQ-030 At a cs_n rise with bit_cnt==0, no action SHALL be taken.
REQ-031 Readback: on the first detected spi_clk fall with bit_cnt==8 and command==CMD_RD, the output shift register SHALL load relay_q.
REQ-032 Readback: each later spi_clk fall in DATA SHALL shift the output register left, filling with 0.
REQ-033 miso SHALL equal the MSB of the output shift register while in DATA with command==CMD_RD, and 0 at all other times.
REQ-034 A write SHALL never alter the readback of a frame already in progress.
REQ-035 wr_strobe and frame_err SHALL never be high in the same clk.

Reset
REQ-036 While reset is high, the synchronous reset SHALL force: relay_q=0, miso=0, wr_strobe=0, frame_err=0, busy=0, bit_cnt=0, command=0, all shift registers=0, and synchronizers to cs_n=1, spi_clk=0, mosi=0.
REQ-037 After reset release with synchronized cs_n low, the FSM SHALL enter ABORT and discard the remainder of the frame; a reset mid-frame SHALL therefore never produce wr_strobe or frame_err for that frame.

Verification (WIDTH=16, clk = 8x spi_clk)
REQ-038 Write 24 bits 8'h01,16'hA55A -> one wr_strobe pulse, relay_q=16'hA55A, frame_err=0.
REQ-039 After REQ-038, read 24 bits 8'h02 plus 16 dummy bits -> miso bits 9..24 = 16'hA55A MSB first, relay_q unchanged, no pulses.
REQ-040 Write 8'h01 with only 15 data bits, and separately with 17 data bits -> frame_err pulse each time, relay_q stays 16'hA55A.
REQ-041 Command 8'h7E, 24 bits -> frame_err pulse; 5-bit frame -> frame_err pulse; cs_n toggle with 0 bits -> no pulse.
REQ-042 Assert reset after 12 bits of a write frame, release with cs_n still low, clock the remaining 12 bits -> relay_q=0, no wr_strobe, busy=1 until cs_n rises, then the next valid write succeeds.
REQ-043 cs_n rise detected in the same clk as the final spi_clk rise -> that bit is discarded, bit_cnt=23, frame_err pulses.

Source files
------------

// File: rtl/spi_relay_ctrl.sv
// spi_relay_ctrl: SPI (mode 0) slave that loads a WIDTH-bit relay drive
// register from a write frame and shifts it back out on a readback frame.
// All SPI pins are sampled through synchronizers into the clk domain.
module spi_relay_ctrl #(
  parameter int unsigned WIDTH  = 48,
  parameter logic [7:0]  CMD_WR = 8'h01,
  parameter logic [7:0]  CMD_RD = 8'h02
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] relay_q,
  output logic             wr_strobe,
  output logic             frame_err,
  output logic             busy
);

  // bit_cnt runs 0..8+WIDTH, and one step further to flag an overrun
  localparam int unsigned CNT_MAX = 8 + WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_CMD_DONE = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(8 + WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Synchronizer chains: [0] = stage 1, [1] = stage 2, [2] = edge-detect delay
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  // Counts the clocks after reset until every synchronizer stage holds a real sample
  logic [1:0] settle_q, settle_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] relay_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic             frame_err_q, frame_err_d;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;
  logic mosi_bit;
  logic sync_ready;

  // Shift each SPI pin one stage further down its synchronizer chain
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
    cs_sync_d   = {cs_sync_q[1:0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  // Synchronizer and settle registers, reset to the idle bus levels
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      settle_q    <= 2'd0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
    end
  end

  assign sclk_rise  =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign cs_fall    = ~cs_sync_q[1]   &  cs_sync_q[2];
  assign cs_rise    =  cs_sync_q[1]   & ~cs_sync_q[2];
  assign mosi_bit   =  mosi_sync_q[1];
  // A cs_n fall seen before the chain has refilled is the reset value
  // draining out while cs_n was already low, i.e. a frame joined mid-way
  assign sync_ready = (settle_q == 2'd3);

  // Frame FSM: bit capture, end-of-frame judgement and readback shifting
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    out_d       = out_q;
    relay_d     = relay_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (sync_ready) begin
            state_d   = CMD;
            bit_cnt_d = CNT_ZERO;
            cmd_d     = 8'h00;
            data_d    = '0;
            out_d     = '0;
          end else begin
            state_d = ABORT;
          end
        end
      end

      CMD, DATA: begin
        if (cs_rise) begin
          // cs_n rise wins over any spi_clk edge seen in the same clk
          state_d = IDLE;
          if (bit_cnt_q == CNT_ZERO) begin
            frame_err_d = 1'b0;
          end else if (bit_cnt_q < CNT_CMD_DONE) begin
            frame_err_d = 1'b1;
          end else if (cmd_q == CMD_WR) begin
            if (bit_cnt_q == CNT_FULL) begin
              relay_d     = data_q;
              wr_strobe_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (cmd_q != CMD_RD) begin
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
          if (state_q == CMD) begin
            cmd_d = {cmd_q[6:0], mosi_bit};
            if (bit_cnt_q == CNT_CMD_LAST) begin
              state_d = DATA;
            end
          end else begin
            data_d = {data_q[WIDTH-2:0], mosi_bit};
          end
        end else if (sclk_fall && (state_q == DATA) && (cmd_q == CMD_RD)) begin
          // Snapshot the relays once, so a later write cannot disturb this readback
          if (bit_cnt_q == CNT_CMD_DONE) begin
            out_d = relay_q;
          end else begin
            out_d = {out_q[WIDTH-2:0], 1'b0};
          end
        end
      end

      ABORT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state, shift registers, relay register and output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= CNT_ZERO;
      cmd_q       <= 8'h00;
      data_q      <= '0;
      out_q       <= '0;
      relay_q     <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      out_q       <= out_d;
      relay_q     <= relay_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
  assign miso      = ((state_q == DATA) && (cmd_q == CMD_RD)) ? out_q[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_spi_relay_ctrl.sv
// tb_spi_relay_ctrl: drives SPI frames into spi_relay_ctrl (WIDTH=16,
// clk = 8x spi_clk) and compares pulses, relay register and miso stream
// against a frame-level reference model.
module tb_spi_relay_ctrl;

  localparam int         W      = 16;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam int         HALF   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_clk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [W-1:0] relay_q;
  logic         wr_strobe;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int wrCnt = 0;
  int errCnt = 0;
  int bothCnt = 0;

  logic [W-1:0] relayModel;

  spi_relay_ctrl #(
    .WIDTH (W),
    .CMD_WR(CMD_WR),
    .CMD_RD(CMD_RD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .relay_q  (relay_q),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Tally pulse-clocks of the two strobes, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_strobe) wrCnt++;
    if (frame_err) errCnt++;
    if (wr_strobe && frame_err) bothCnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one SPI mode-0 frame; miso is sampled just before each rising edge
  task automatic applyStimulus(input logic [63:0] bits, input int nbits, input bit csStart,
                               input bit csEnd, input bit race, output logic [63:0] rx);
    rx = '0;
    @(negedge clk);
    if (csStart) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = bits[nbits-1-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[62:0], miso};
      spi_clk = 1'b1;
      if (race && (i == nbits - 1)) cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    if (csEnd && !race) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
    end
    repeat (6) @(negedge clk);
  endtask

  // Frame-level reference: judges the whole frame from the bits the slave captures
  task automatic modelFrame(input logic [63:0] bits, input int nbits, input bit race,
                            output int expWr, output int expErr, output logic [63:0] expRx);
    int n;
    logic [7:0] cmd;
    n      = race ? nbits - 1 : nbits;
    expWr  = 0;
    expErr = 0;
    expRx  = '0;
    cmd    = (nbits >= 8) ? 8'(bits >> (nbits - 8)) : 8'h00;
    for (int i = 0; i < nbits; i++) begin
      expRx = {expRx[62:0], ((cmd == CMD_RD) && (i >= 8) && (i < 8 + W)) ? relayModel[8 + W - 1 - i] : 1'b0};
    end
    if (n == 0) begin
      expErr = 0;
    end else if (n < 8) begin
      expErr = 1;
    end else if (cmd == CMD_WR) begin
      if (n == 8 + W) begin
        relayModel = W'(bits >> (nbits - n));
        expWr      = 1;
      end else begin
        expErr = 1;
      end
    end else if (cmd != CMD_RD) begin
      expErr = 1;
    end
  endtask

  task automatic runFrame(input string tag, input logic [63:0] bits, input int nbits, input bit race);
    int wr0, er0, expWr, expErr;
    logic [63:0] expRx, rx;
    wr0 = wrCnt;
    er0 = errCnt;
    modelFrame(bits, nbits, race, expWr, expErr, expRx);
    applyStimulus(bits, nbits, 1'b1, 1'b1, race, rx);
    checkOutput({tag, "/wr_strobe"}, 64'(wrCnt - wr0), 64'(expWr));
    checkOutput({tag, "/frame_err"}, 64'(errCnt - er0), 64'(expErr));
    checkOutput({tag, "/relay_q"}, 64'(relay_q), 64'(relayModel));
    checkOutput({tag, "/busy"}, 64'(busy), 64'd0);
    if (nbits > 0) checkOutput({tag, "/miso"}, rx, expRx);
  endtask

  initial begin
    logic [63:0] bits, rx, dat, mask;
    logic [7:0]  cmd;
    int          nbits, sel, wr0, er0;

    reset      = 1'b1;
    spi_clk    = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b0;
    relayModel = '0;
    repeat (4) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset/relay_q", 64'(relay_q), 64'd0);
    checkOutput("reset/miso", 64'(miso), 64'd0);
    checkOutput("reset/wr_strobe", 64'(wr_strobe), 64'd0);
    checkOutput("reset/frame_err", 64'(frame_err), 64'd0);
    checkOutput("reset/busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] directed frames");
    runFrame("write_a55a", {40'd0, CMD_WR, 16'hA55A}, 24, 1'b0);
    runFrame("read_a55a", {40'd0, CMD_RD, 16'h0000}, 24, 1'b0);
    runFrame("write_short", {41'd0, CMD_WR, 15'h1234}, 23, 1'b0);
    runFrame("write_long", {39'd0, CMD_WR, 17'h1BEEF}, 25, 1'b0);
    runFrame("bad_cmd", {40'd0, 8'h7E, 16'h5555}, 24, 1'b0);
    runFrame("five_bits", 64'h15, 5, 1'b0);
    runFrame("zero_bits", 64'h0, 0, 1'b0);
    runFrame("read_short", {48'd0, CMD_RD, 8'h00}, 16, 1'b0);

    $display("[TB] reset in mid-frame");
    wr0 = wrCnt;
    er0 = errCnt;
    bits = {40'd0, CMD_WR, 16'hC3C3};
    applyStimulus(bits >> 12, 12, 1'b1, 1'b0, 1'b0, rx);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset/busy_in_reset", 64'(busy), 64'd0);
    checkOutput("midreset/relay_in_reset", 64'(relay_q), 64'd0);
    reset = 1'b0;
    relayModel = '0;
    applyStimulus(bits & 64'hFFF, 12, 1'b0, 1'b0, 1'b0, rx);
    checkOutput("midreset/busy_abort", 64'(busy), 64'd1);
    checkOutput("midreset/relay_q", 64'(relay_q), 64'd0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midreset/busy_after", 64'(busy), 64'd0);
    checkOutput("midreset/wr_strobe", 64'(wrCnt - wr0), 64'd0);
    checkOutput("midreset/frame_err", 64'(errCnt - er0), 64'd0);
    runFrame("write_after_reset", {40'd0, CMD_WR, 16'h3CA5}, 24, 1'b0);

    $display("[TB] cs_n rise racing the last spi_clk rise");
    runFrame("race_last_bit", {40'd0, CMD_WR, 16'h0F0F}, 24, 1'b1);
    runFrame("read_after_race", {40'd0, CMD_RD, 16'hFFFF}, 24, 1'b0);

    $display("[TB] random frames");
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 3));
      cmd = (sel == 0) ? CMD_WR : (sel == 1) ? CMD_RD : 8'($urandom);
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1:    nbits = 24;
        2:       nbits = int'($urandom_range(0, 30));
        3:       nbits = 23;
        4:       nbits = 25;
        default: nbits = int'($urandom_range(1, 7));
      endcase
      dat = {$urandom, $urandom};
      if (nbits >= 8) begin
        mask = (64'd1 << (nbits - 8)) - 64'd1;
        bits = ({56'd0, cmd} << (nbits - 8)) | (dat & mask);
      end else begin
        mask = (64'd1 << nbits) - 64'd1;
        bits = dat & mask;
      end
      runFrame($sformatf("rand%0d", k), bits, nbits, 1'b0);
    end
    runFrame("final_read", {40'd0, CMD_RD, 16'h0000}, 24, 1'b0);

    checkOutput("never_both_pulses", 64'(bothCnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
